// File: rtl/timer_prescaler_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared defaults, divide-limit helper and channel config type
//               for the multi-channel timer prescaler.
// Revision    : 1.0
// ============================================================================
package timer_pkg;

    localparam int c_DIV_W = 4;
    localparam int c_PSC_W = 8;

    // Terminal count for exponent k, clamped to psc_w; psc_w must stay below 32.
    function automatic logic [31:0] psc_limit(input int k, input int psc_w);
        int kc;
        kc = (k > psc_w) ? psc_w : k;
        return (32'd1 << kc) - 32'd1;
    endfunction

    typedef struct packed {
        logic               timer_en;
        logic               div_en;
        logic [c_DIV_W-1:0] div_val;
        logic               dbg_freeze;
    } timer_ch_cfg_t;

endpackage
`default_nettype wire

// File: rtl/timer_psc_ch.sv
`default_nettype none
// ============================================================================
// Module      : timer_psc_ch
// Description : One prescaler channel: counter, divider shadow and count-enable.
// Revision    : 1.0
// ============================================================================
module timer_psc_ch
    import timer_pkg::*;
#(
    parameter int DIV_W = c_DIV_W,
    parameter int PSC_W = c_PSC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timer_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             frozen,
    output logic             cnt_en
);

    logic [PSC_W-1:0] r_psc_cnt;
    logic [DIV_W-1:0] r_shadow;
    logic [PSC_W-1:0] w_limit;
    logic             w_ratio1;
    logic             w_chg;
    logic             w_tc;
    logic             w_run;

    // A divider change only matters while the channel is actually dividing.
    always_comb begin
        w_ratio1 = !div_en || (div_val == '0);
        w_limit  = PSC_W'(psc_limit(int'(div_val), PSC_W));
        w_chg    = timer_en && !w_ratio1 && (div_val != r_shadow);
        w_tc     = (r_psc_cnt == w_limit);
        w_run    = timer_en && !frozen;
        cnt_en   = rst_n && w_run && !w_chg && (w_ratio1 || w_tc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc_cnt <= '0;
            r_shadow  <= '0;
        end else if (!timer_en || w_ratio1) begin
            r_psc_cnt <= '0;
        end else if (w_chg) begin
            r_psc_cnt <= '0;
            r_shadow  <= div_val;
        end else if (frozen) begin
            r_psc_cnt <= r_psc_cnt;
        end else if (w_tc) begin
            r_psc_cnt <= '0;
        end else begin
            r_psc_cnt <= r_psc_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_prescaler_mc.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler_mc
// Description : Multi-channel prescaler / count-enable generator with halt
//               handshake and per-channel debug freeze.
// Revision    : 1.0
// ============================================================================
module timer_prescaler_mc
    import timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = c_DIV_W,
    parameter int PSC_W  = c_PSC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       timer_en,
    input  logic [NUM_CH-1:0]       div_en,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       dbg_freeze,
    input  logic                    debug_mode,
    input  logic                    halt_req,
    output logic                    halt_ack,
    output logic [NUM_CH-1:0]       cnt_en
);

    logic r_halt_ack;
    logic w_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt_ack <= 1'b0;
        end else begin
            r_halt_ack <= halt_req;
        end
    end

    // The raw request freezes channels in its own cycle, ahead of the ack.
    assign w_halt   = halt_req | r_halt_ack;
    assign halt_ack = r_halt_ack;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            timer_ch_cfg_t w_cfg;
            logic          w_frozen;

            assign w_cfg.timer_en   = timer_en[c];
            assign w_cfg.div_en     = div_en[c];
            assign w_cfg.div_val    = c_DIV_W'(div_val[c*DIV_W +: DIV_W]);
            assign w_cfg.dbg_freeze = dbg_freeze[c];
            assign w_frozen         = w_halt | (debug_mode & w_cfg.dbg_freeze);

            timer_psc_ch #(
                .DIV_W (c_DIV_W),
                .PSC_W (PSC_W)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .timer_en (w_cfg.timer_en),
                .div_en   (w_cfg.div_en),
                .div_val  (w_cfg.div_val),
                .frozen   (w_frozen),
                .cnt_en   (cnt_en[c])
            );
        end
    endgenerate

endmodule
`default_nettype wire
